// File: rtl/uart_rx_buf.sv
// uart_rx_buf: oversampled UART receiver feeding a first-word-fall-through character FIFO.
// Optional build macro UART_RX_MAJVOTE_EN enables 2-of-3 majority sampling of each bit.
module uart_rx_buf #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned CNTW      = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            brgCLKEN,
    input  logic [1:0]      length,
    input  logic [1:0]      parity,
    input  logic            stop,
    input  logic            rxd,
    input  logic            rd,
    output logic [7:0]      data,
    output logic            pare,
    output logic            frme,
    output logic            brk,
    output logic            empty,
    output logic            full,
    output logic [CNTW-1:0] level,
    output logic            ovre,
    output logic            intr
);

    localparam int unsigned DivW  = $clog2(OVERSAMPLE);
    localparam int unsigned AddrW = $clog2(DEPTH);
`ifdef UART_RX_MAJVOTE_EN
    localparam int unsigned Adj = 1;
`else
    localparam int unsigned Adj = 0;
`endif
    localparam logic [DivW-1:0] DivBit     = DivW'(OVERSAMPLE - 1);
    localparam logic [DivW-1:0] DivHalf    = DivW'(OVERSAMPLE / 2 - 1);
    localparam logic [DivW-1:0] DivBitEvt  = DivW'(OVERSAMPLE - 1 - Adj);
    localparam logic [DivW-1:0] DivHalfEvt = DivW'(OVERSAMPLE / 2 - 1 - Adj);

    typedef enum logic [3:0] {
        StIdle, StStart, StData, StParity, StStop1, StStop2, StWait, StBrkWait, StDone
    } state_e;

    logic            sync_q, din_q;
    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            pare_q, pare_d, frme_q, frme_d, brk_q, brk_d, parbit_q, parbit_d;
    logic            bit_evt, bit_val, par_en, bit_st;
    logic [2:0]      last_bit;
`ifdef UART_RX_MAJVOTE_EN
    logic            vote_q, vote_d, s0_q, s0_d, s1_q, s1_d;
`endif

    logic [10:0]      mem_q [DEPTH];
    logic [10:0]      mem_d [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d, remain;
    logic [10:0]      head_q, head_d, wdata;
    logic             ovre_q, ovre_d, wr, push, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            din_q  <= 1'b1;
        end else begin
            sync_q <= rxd;
            din_q  <= sync_q;
        end
    end

    assign par_en   = (parity == 2'b01) || (parity == 2'b10);
    assign last_bit = 3'(length) + 3'd4;
    assign bit_st   = (state_q == StData) || (state_q == StParity) ||
                      (state_q == StStop1) || (state_q == StStop2);

`ifdef UART_RX_MAJVOTE_EN
    assign bit_evt = brgCLKEN && vote_q;
    assign bit_val = (s1_q & s0_q) | (s1_q & din_q) | (s0_q & din_q);
`else
    assign bit_evt = brgCLKEN && bit_st && (div_q == '0);
    assign bit_val = din_q;
`endif

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        pare_d   = pare_q;
        frme_d   = frme_q;
        brk_d    = brk_q;
        parbit_d = parbit_q;
        if (brgCLKEN && (div_q != '0)) div_d = div_q - DivW'(1);
`ifdef UART_RX_MAJVOTE_EN
        vote_d = vote_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        // Centre sample arms the vote; the decision happens one tick later.
        if (brgCLKEN && bit_st && !vote_q) begin
            if (div_q == DivW'(1)) s1_d = din_q;
            if (div_q == '0) begin
                s0_d   = din_q;
                vote_d = 1'b1;
                div_d  = DivBit;
            end
        end
        if (bit_evt) vote_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (brgCLKEN && !din_q) begin
                    state_d = StStart;
                    div_d   = DivHalf;
                end
            end
            StStart: begin
                if (brgCLKEN) begin
                    if (din_q) begin
                        state_d = StIdle;
                    end else if (div_q == '0) begin
                        state_d  = StData;
                        div_d    = DivBit;
                        bitcnt_d = '0;
                        shift_d  = '0;
                        pare_d   = 1'b0;
                        frme_d   = 1'b0;
                        brk_d    = 1'b0;
                        parbit_d = 1'b0;
                    end
                end
            end
            StData: begin
                if (bit_evt) begin
                    shift_d[bitcnt_q] = bit_val;
                    bitcnt_d          = bitcnt_q + 3'd1;
                    div_d             = DivBitEvt;
                    if (bitcnt_q == last_bit) state_d = par_en ? StParity : StStop1;
                end
            end
            StParity: begin
                if (bit_evt) begin
                    parbit_d = bit_val;
                    pare_d   = bit_val ^ (^shift_q) ^ (parity == 2'b01);
                    div_d    = DivBitEvt;
                    state_d  = StStop1;
                end
            end
            StStop1: begin
                if (bit_evt) begin
                    frme_d = !bit_val;
                    if ((shift_q == '0) && !(par_en && parbit_q) && !bit_val) begin
                        brk_d   = 1'b1;
                        state_d = StDone;
                    end else if (stop) begin
                        state_d = StStop2;
                        div_d   = DivBitEvt;
                    end else begin
                        state_d = StWait;
                        div_d   = DivHalfEvt;
                    end
                end
            end
            StStop2: begin
                if (bit_evt) begin
                    frme_d  = frme_q | !bit_val;
                    state_d = StWait;
                    div_d   = DivHalfEvt;
                end
            end
            StWait: begin
                if (brgCLKEN && (div_q == '0)) state_d = StDone;
            end
            StDone: begin
                state_d = brk_q ? StBrkWait : StIdle;
            end
            StBrkWait: begin
                if (brgCLKEN && din_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (clr) begin
            state_d = StIdle;
`ifdef UART_RX_MAJVOTE_EN
            vote_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            div_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            pare_q   <= 1'b0;
            frme_q   <= 1'b0;
            brk_q    <= 1'b0;
            parbit_q <= 1'b0;
`ifdef UART_RX_MAJVOTE_EN
            vote_q   <= 1'b0;
            s0_q     <= 1'b1;
            s1_q     <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            pare_q   <= pare_d;
            frme_q   <= frme_d;
            brk_q    <= brk_d;
            parbit_q <= parbit_d;
`ifdef UART_RX_MAJVOTE_EN
            vote_q   <= vote_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
`endif
        end
    end

    assign wr     = (state_q == StDone) && !clr;
    assign wdata  = {brk_q, frme_q, pare_q, shift_q};
    assign pop    = rd && (count_q != '0);
    assign push   = wr && ((count_q != CNTW'(DEPTH)) || pop);
    assign remain = count_q - CNTW'(pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        ovre_d   = ovre_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
            ovre_d   = 1'b0;
        end else begin
            if (wr && !push) ovre_d = 1'b1;
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AddrW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AddrW'(1);
            count_d = count_q + CNTW'(push) - CNTW'(pop);
            // Head register tracks the entry that will be at the front next cycle.
            if (count_d == '0) begin
                head_d = '0;
            end else if (remain == '0) begin
                head_d = wdata;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            ovre_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            ovre_q   <= ovre_d;
        end
    end

    assign data  = head_q[7:0];
    assign pare  = head_q[8];
    assign frme  = head_q[9];
    assign brk   = head_q[10];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNTW'(DEPTH));
    assign level = count_q;
    assign ovre  = ovre_q;
    assign intr  = wr;

endmodule

// File: tb/tb_uart_rx_buf.sv
// tb_uart_rx_buf: vector table, corner sequences and random frames against a frame-level model.
module tb_uart_rx_buf;

    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0, rst_n = 1'b0, clr = 1'b0, brg = 1'b0;
    logic            stop = 1'b0, rxd = 1'b1, rd = 1'b0;
    logic [1:0]      length = 2'b11, parity = 2'b00;
    logic [7:0]      data;
    logic            pare, frme, brk, empty, full, ovre, intr;
    logic [CNTW-1:0] level;

    int n_pass = 0, n_tot = 0, intr_cnt = 0, cnt0 = 0;
    bit seen;

    uart_rx_buf #(.OVERSAMPLE(OS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .brgCLKEN(brg), .length(length),
        .parity(parity), .stop(stop), .rxd(rxd), .rd(rd), .data(data), .pare(pare),
        .frme(frme), .brk(brk), .empty(empty), .full(full), .level(level), .ovre(ovre),
        .intr(intr)
    );

    always #5 clk = ~clk;
    always @(negedge clk) brg <= ~brg;
    always @(posedge clk) if (intr) intr_cnt <= intr_cnt + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  len;
        logic [1:0]  par;
        logic        stp;
        logic [7:0]  val;
        logic        pb;
        logic        s1;
        logic        s2;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[12];
    logic [10:0] q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic chk_head(input string nm, input logic [10:0] exp);
        chk({nm, ".data"}, int'(data), int'(exp[7:0]));
        chk({nm, ".pare"}, int'(pare), int'(exp[8]));
        chk({nm, ".frme"}, int'(frme), int'(exp[9]));
        chk({nm, ".brk"}, int'(brk), int'(exp[10]));
    endtask

    task automatic tick();
        do @(posedge clk); while (!brg);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] val, input logic pb, input logic s1, input logic s2);
        int nb = int'(length) + 5;
        hold(1'b0, OS);
        for (int i = 0; i < nb; i++) hold(val[i], OS);
        if ((parity == 2'b01) || (parity == 2'b10)) hold(pb, OS);
        hold(s1, OS);
        if (stop) hold(s2, OS);
        hold(1'b1, 2 * OS);
    endtask

    task automatic pop();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    // Expected {brk, frme, pare, data} from the frame's fields.
    function automatic logic [10:0] model(input logic [1:0] len, input logic [1:0] par,
                                          input logic stp, input logic [7:0] val,
                                          input logic pb, input logic s1, input logic s2);
        int nb = int'(len) + 5;
        logic [7:0] d = val & 8'((1 << nb) - 1);
        bit pen = (par == 2'b01) || (par == 2'b10);
        bit pe = 1'b0;
        bit bk, fe;
        if (pen) pe = ((($countones(d) + int'(pb)) % 2) == 1) != (par == 2'b01);
        bk = (d == 8'h00) && !(pen && pb) && !s1;
        fe = !s1 || (stp && !bk && !s2);
        return {bk, fe, pe, d};
    endfunction

    initial begin
        tbl[0]  = '{2'd3, 2'd0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 11'h0A5};
        tbl[1]  = '{2'd2, 2'd2, 1'b0, 8'h41, 1'b1, 1'b1, 1'b1, 11'h141};
        tbl[2]  = '{2'd2, 2'd2, 1'b0, 8'h41, 1'b0, 1'b1, 1'b1, 11'h041};
        tbl[3]  = '{2'd0, 2'd0, 1'b1, 8'h1F, 1'b0, 1'b1, 1'b0, 11'h21F};
        tbl[4]  = '{2'd1, 2'd1, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b1, 11'h02A};
        tbl[5]  = '{2'd3, 2'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 11'h000};
        tbl[6]  = '{2'd3, 2'd0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 11'h23C};
        tbl[7]  = '{2'd3, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 11'h600};
        tbl[8]  = '{2'd0, 2'd2, 1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 11'h115};
        tbl[9]  = '{2'd2, 2'd0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 11'h07F};
        tbl[10] = '{2'd3, 2'd3, 1'b0, 8'h81, 1'b1, 1'b1, 1'b1, 11'h081};
        tbl[11] = '{2'd3, 2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 11'h600};

        repeat (3) @(negedge clk);
        chk("rst.empty", int'(empty), 1);
        chk("rst.full", int'(full), 0);
        chk("rst.level", int'(level), 0);
        chk("rst.ovre", int'(ovre), 0);
        chk("rst.intr", int'(intr), 0);
        chk_head("rst", 11'h000);
        rst_n = 1'b1;
        hold(1'b1, 2 * OS);

        pop();
        chk("rd_empty.level", int'(level), 0);
        chk("rd_empty.empty", int'(empty), 1);

        for (int i = 0; i < 12; i++) begin
            length = tbl[i].len;
            parity = tbl[i].par;
            stop   = tbl[i].stp;
            hold(1'b1, OS);
            cnt0 = intr_cnt;
            send(tbl[i].val, tbl[i].pb, tbl[i].s1, tbl[i].s2);
            @(negedge clk);
            chk($sformatf("vec%0d.intr", i), intr_cnt, cnt0 + 1);
            chk($sformatf("vec%0d.level", i), int'(level), 1);
            chk($sformatf("vec%0d.empty", i), int'(empty), 0);
            chk_head($sformatf("vec%0d", i), tbl[i].exp);
            pop();
            chk($sformatf("vec%0d.empty_after_rd", i), int'(empty), 1);
        end

        // Long break: one entry only, nothing more while idle.
        length = 2'd3; parity = 2'd0; stop = 1'b0;
        cnt0 = intr_cnt;
        hold(1'b0, 30 * OS);
        hold(1'b1, 2 * OS);
        @(negedge clk);
        chk("brk.intr", intr_cnt, cnt0 + 1);
        chk("brk.level", int'(level), 1);
        chk_head("brk", 11'h600);
        pop();
        hold(1'b1, 3 * OS);
        chk("brk.no_more", intr_cnt, cnt0 + 1);
        send(8'h5A, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("brk.next_intr", intr_cnt, cnt0 + 2);
        chk_head("brk.next", 11'h05A);
        pop();

        // Glitch on the line start is rejected.
        cnt0 = intr_cnt;
        hold(1'b0, 4);
        hold(1'b1, 3 * OS);
        @(negedge clk);
        chk("glitch.intr", intr_cnt, cnt0);
        chk("glitch.empty", int'(empty), 1);
        send(8'hC3, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk_head("glitch.next", 11'h0C3);
        pop();

        // Fill, push with rd in the write cycle, then overrun.
        for (int v = 1; v <= 4; v++) send(8'(v), 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("fill.level", int'(level), 4);
        chk("fill.full", int'(full), 1);
        chk("fill.ovre", int'(ovre), 0);
        chk("fill.head", int'(data), 1);
        seen = 1'b0;
        fork
            send(8'h05, 1'b0, 1'b1, 1'b1);
            begin
                for (int c = 0; c < 2000 && !seen; c++) begin
                    @(negedge clk);
                    if (intr) begin
                        rd = 1'b1;
                        seen = 1'b1;
                        @(negedge clk);
                        rd = 1'b0;
                    end
                end
            end
        join
        chk("rdwr.seen", int'(seen), 1);
        @(negedge clk);
        chk("rdwr.level", int'(level), 4);
        chk("rdwr.ovre", int'(ovre), 0);
        chk("rdwr.head", int'(data), 2);
        send(8'h06, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("ovr.level", int'(level), 4);
        chk("ovr.ovre", int'(ovre), 1);
        chk("ovr.head", int'(data), 2);
        for (int v = 2; v <= 5; v++) begin
            chk($sformatf("drain%0d.data", v), int'(data), v);
            pop();
        end
        chk("drain.empty", int'(empty), 1);
        chk("drain.ovre_sticky", int'(ovre), 1);
        send(8'h77, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("clr.empty", int'(empty), 1);
        chk("clr.ovre", int'(ovre), 0);
        chk("clr.level", int'(level), 0);
        chk("clr.data", int'(data), 0);

`ifdef UART_RX_MAJVOTE_EN
        length = 2'd3; parity = 2'd0; stop = 1'b0;
        hold(1'b0, OS);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                hold(1'b1, 7);
                hold(1'b0, 1);
                hold(1'b1, 8);
            end else begin
                hold(((8'h55 >> i) & 8'h01) != 8'h00, OS);
            end
        end
        hold(1'b1, 3 * OS);
        @(negedge clk);
        chk_head("majvote", 11'h055);
        pop();
`endif

        for (int it = 0; it < 16; it++) begin
            logic [7:0] v;
            logic pb, s1, s2;
            length = 2'($urandom_range(0, 3));
            parity = 2'($urandom_range(0, 3));
            stop   = 1'($urandom_range(0, 1));
            v  = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 5) != 0);
            s2 = ($urandom_range(0, 5) != 0);
            if (it == 3) begin
                v = 8'h00; s1 = 1'b0;
            end
            cnt0 = intr_cnt;
            send(v, pb, s1, s2);
            q.push_back(model(length, parity, stop, v, pb, s1, s2));
            @(negedge clk);
            chk($sformatf("rnd%0d.intr", it), intr_cnt, cnt0 + 1);
            chk($sformatf("rnd%0d.level", it), int'(level), q.size());
            if ((q.size() == 3) || ($urandom_range(0, 1) == 1) || (it == 15)) begin
                while (q.size() > 0) begin
                    chk_head($sformatf("rnd%0d", it), q.pop_front());
                    pop();
                end
                chk($sformatf("rnd%0d.empty", it), int'(empty), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
